// File: rtl/packet_tx_arbiter_if.sv
// AXI-Stream beat bundle (valid/ready, data, keep, size sideband, last) shared by
// the two packet sources and the merged MAC-facing output of packet_tx_arbiter.
interface packet_tx_arbiter_if #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int USER_W = 16
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [USER_W-1:0] tuser_size;
  logic              tlast;

  modport master (
    output tvalid, tdata, tkeep, tuser_size, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tuser_size, tlast,
    output tready
  );
endinterface

// File: rtl/packet_tx_arbiter.sv
// Packet-granular merge of RoCEv2 (RDMA) and non-RoCEv2 (QDMA) streams toward the MAC.
// Build option PKT_TX_ARB_ROCE_PRIO_EN: strict RoCE priority on ties instead of round-robin.
//
// state       | meaning
// ARB_IDLE    | between packets; grant decided combinationally, no bubble
// ARB_ROCE    | locked to RoCEv2 source until its tlast is accepted
// ARB_NONROCE | locked to non-RoCEv2 source until its tlast is accepted
module packet_tx_arbiter #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = 64,
  parameter int AXIS_USER_WIDTH = 16
) (
  input  logic                      axis_aclk,
  input  logic                      axis_rst,
  packet_tx_arbiter_if.slave        s_axis_roce,
  packet_tx_arbiter_if.slave        s_axis_non_roce,
  packet_tx_arbiter_if.master       m_axis,
  output logic [31:0]               roce_pkt_cnt,
  output logic [31:0]               non_roce_pkt_cnt
);

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ROCE    = 2'd1,
    ARB_NONROCE = 2'd2
  } arb_state_e;

  localparam logic GRANT_NON  = 1'b0;
  localparam logic GRANT_ROCE = 1'b1;

  arb_state_e                 state_q, state_d;
  logic                       last_grant_q, last_grant_d;

  logic                       m_valid_q, m_valid_d;
  logic [AXIS_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [AXIS_KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
  logic [AXIS_USER_WIDTH-1:0] m_user_q, m_user_d;
  logic                       m_last_q, m_last_d;

  logic [31:0]                roce_cnt_q, roce_cnt_d;
  logic [31:0]                non_cnt_q, non_cnt_d;

  logic                       out_free;
  logic                       tie_roce;
  logic                       sel_roce, sel_non;
  logic                       roce_ready, non_ready;
  logic                       roce_acc, non_acc;

`ifdef PKT_TX_ARB_ROCE_PRIO_EN
  assign tie_roce = 1'b1;
`else
  assign tie_roce = (last_grant_q == GRANT_NON);
`endif

  assign out_free = !m_valid_q || m_axis.tready;

  always_comb begin : grant_select
    sel_roce = 1'b0;
    sel_non  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (s_axis_roce.tvalid && s_axis_non_roce.tvalid) begin
          sel_roce = tie_roce;
          sel_non  = !tie_roce;
        end else begin
          sel_roce = s_axis_roce.tvalid;
          sel_non  = s_axis_non_roce.tvalid;
        end
      end
      // A locked source keeps the grant even while its tvalid is low.
      ARB_ROCE:    sel_roce = 1'b1;
      ARB_NONROCE: sel_non  = 1'b1;
      default: begin
        sel_roce = 1'b0;
        sel_non  = 1'b0;
      end
    endcase
  end

  assign roce_ready = sel_roce && out_free && !axis_rst;
  assign non_ready  = sel_non && out_free && !axis_rst;
  assign roce_acc   = s_axis_roce.tvalid && roce_ready;
  assign non_acc    = s_axis_non_roce.tvalid && non_ready;

  assign s_axis_roce.tready     = roce_ready;
  assign s_axis_non_roce.tready = non_ready;

  always_comb begin : next_state
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (roce_acc) begin
      last_grant_d = GRANT_ROCE;
      state_d      = s_axis_roce.tlast ? ARB_IDLE : ARB_ROCE;
    end else if (non_acc) begin
      last_grant_d = GRANT_NON;
      state_d      = s_axis_non_roce.tlast ? ARB_IDLE : ARB_NONROCE;
    end
  end

  always_comb begin : out_stage
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_user_d  = m_user_q;
    m_last_d  = m_last_q;
    if (roce_acc) begin
      m_valid_d = 1'b1;
      m_data_d  = s_axis_roce.tdata;
      m_keep_d  = s_axis_roce.tkeep;
      m_user_d  = s_axis_roce.tuser_size;
      m_last_d  = s_axis_roce.tlast;
    end else if (non_acc) begin
      m_valid_d = 1'b1;
      m_data_d  = s_axis_non_roce.tdata;
      m_keep_d  = s_axis_non_roce.tkeep;
      m_user_d  = s_axis_non_roce.tuser_size;
      m_last_d  = s_axis_non_roce.tlast;
    end else if (m_axis.tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_comb begin : pkt_counters
    roce_cnt_d = roce_cnt_q;
    non_cnt_d  = non_cnt_q;
    if (roce_acc && s_axis_roce.tlast) begin
      roce_cnt_d = roce_cnt_q + 32'd1;
    end
    if (non_acc && s_axis_non_roce.tlast) begin
      non_cnt_d = non_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_NON;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_user_q     <= '0;
      m_last_q     <= 1'b0;
      roce_cnt_q   <= '0;
      non_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_user_q     <= m_user_d;
      m_last_q     <= m_last_d;
      roce_cnt_q   <= roce_cnt_d;
      non_cnt_q    <= non_cnt_d;
    end
  end

  assign m_axis.tvalid     = m_valid_q;
  assign m_axis.tdata      = m_data_q;
  assign m_axis.tkeep      = m_keep_q;
  assign m_axis.tuser_size = m_user_q;
  assign m_axis.tlast      = m_last_q;

  assign roce_pkt_cnt     = roce_cnt_q;
  assign non_roce_pkt_cnt = non_cnt_q;

endmodule

// File: tb/tb_packet_tx_arbiter.sv
// Self-checking bench for packet_tx_arbiter: cycle table for tie handling, directed
// lock/backpressure/priority/wrap sequences and a random run against a packet-level model.
module tb_packet_tx_arbiter;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 16;
`ifdef PKT_TX_ARB_ROCE_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  packet_tx_arbiter_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) roce_if ();
  packet_tx_arbiter_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) non_if ();
  packet_tx_arbiter_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) m_if ();
  logic [31:0] roce_cnt, non_cnt;

  packet_tx_arbiter #(.AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_USER_WIDTH(UW)) dut (
    .axis_aclk        (clk),
    .axis_rst         (rst),
    .s_axis_roce      (roce_if),
    .s_axis_non_roce  (non_if),
    .m_axis           (m_if),
    .roce_pkt_cnt     (roce_cnt),
    .non_roce_pkt_cnt (non_cnt)
  );

  typedef struct { logic [31:0] id; logic last; int gap; } drv_t;
  typedef struct { int cyc; logic [31:0] id; logic last; } log_t;
  typedef struct {
    logic rv; logic rl; logic [31:0] rid;
    logic nv; logic nl; logic [31:0] nid;
    logic e_rr; logic e_nr; logic e_mv; logic [31:0] e_mid; logic e_ml;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   pkt_no = 0;
  drv_t q0[$];
  drv_t q1[$];
  log_t expq[$];
  log_t lg[$];
  vec_t vt[$];
  int   exp_cnt[2];
  int   mstate = 0;        // 0 idle, 1 locked roce, 2 locked non-roce
  bit   mlast = 1'b0;      // 1 when roce was granted most recently
  bit   mon_en = 1'b0;
  bit   cnt_chk = 1'b1;
  bit   rnd_done = 1'b0;

  function automatic logic [DW-1:0] fdata(input logic [31:0] id);
    return {16{id}};
  endfunction
  function automatic logic [KW-1:0] fkeep(input logic [31:0] id);
    return {2{id}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual[63:0] %0h required[63:0] %0h (t=%0t)", nm, act[63:0], exp[63:0], $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual event missing, required within bound (t=%0t)", nm, $time);
  endtask

  task automatic set_src(input int s, input logic v, input logic [31:0] id, input logic l);
    if (s == 0) begin
      roce_if.tvalid = v; roce_if.tdata = fdata(id); roce_if.tkeep = fkeep(id);
      roce_if.tuser_size = id[15:0]; roce_if.tlast = l;
    end else begin
      non_if.tvalid = v; non_if.tdata = fdata(id); non_if.tkeep = fkeep(id);
      non_if.tuser_size = id[15:0]; non_if.tlast = l;
    end
  endtask

  task automatic add_pkt(input int s, input int len, input int gap0, input int mid_at, input int mid_gap);
    drv_t b;
    for (int i = 0; i < len; i++) begin
      b.id   = {4'(s + 1), 12'(pkt_no), 16'(i)};
      b.last = (i == len - 1);
      b.gap  = (i == 0) ? gap0 : ((i == mid_at) ? mid_gap : 0);
      if (s == 0) q0.push_back(b); else q1.push_back(b);
    end
    pkt_no++;
  endtask

  // AXIS-legal source: tvalid held until accepted, optional idle cycles before a beat.
  task automatic drive(input int s);
    drv_t b;
    logic acc;
    int   budget;
    forever begin
      if (s == 0) begin
        if (q0.size() == 0) break;
        b = q0.pop_front();
      end else begin
        if (q1.size() == 0) break;
        b = q1.pop_front();
      end
      repeat (b.gap) begin
        set_src(s, 1'b0, b.id, b.last);
        @(posedge clk); #1;
      end
      set_src(s, 1'b1, b.id, b.last);
      budget = 0;
      do begin
        @(negedge clk);
        acc = (s == 0) ? roce_if.tready : non_if.tready;
        @(posedge clk); #1;
        budget++;
      end while (!acc && budget < 500);
      if (!acc) fail_now((s == 0) ? "roce_beat_accept_timeout" : "non_beat_accept_timeout");
    end
    set_src(s, 1'b0, 32'd0, 1'b0);
  endtask

  always @(posedge clk) cyc++;

  logic [DW-1:0] h_data;
  logic [KW-1:0] h_keep;
  logic [UW-1:0] h_user;
  logic          h_last;
  bit            h_chk = 1'b0;

  // Packet-level reference: whole packets, round-robin (or roce priority) on ties,
  // output is the ordered stream of accepted beats.
  always @(negedge clk) begin : mon
    int   cand;
    bit   ofree, er, en;
    log_t e;
    if (!rst && mon_en) begin
      if (h_chk) begin
        chk("bp_tvalid_hold", m_if.tvalid, 1'b1);
        chk_w("bp_tdata_hold", m_if.tdata, h_data);
        chk("bp_tkeep_hold", m_if.tkeep, h_keep);
        chk("bp_tuser_hold", m_if.tuser_size, h_user);
        chk("bp_tlast_hold", m_if.tlast, h_last);
      end
      h_chk  = m_if.tvalid && !m_if.tready;
      h_data = m_if.tdata; h_keep = m_if.tkeep; h_user = m_if.tuser_size; h_last = m_if.tlast;

      if (m_if.tvalid && m_if.tready) begin
        if (expq.size() == 0) fail_now("out_unexpected_beat");
        else begin
          e = expq.pop_front();
          chk_w("out_tdata", m_if.tdata, fdata(e.id));
          chk("out_tkeep", m_if.tkeep, fkeep(e.id));
          chk("out_tuser", m_if.tuser_size, e.id[15:0]);
          chk("out_tlast", m_if.tlast, e.last);
          e.cyc = cyc;
          lg.push_back(e);
        end
      end

      if (cnt_chk) begin
        chk("roce_pkt_cnt", roce_cnt, 32'(exp_cnt[0]));
        chk("non_roce_pkt_cnt", non_cnt, 32'(exp_cnt[1]));
      end

      ofree = !m_if.tvalid || m_if.tready;
      cand = -1;
      if (mstate == 1) cand = 0;
      else if (mstate == 2) cand = 1;
      else if (roce_if.tvalid && non_if.tvalid) cand = (PRIO || !mlast) ? 0 : 1;
      else if (roce_if.tvalid) cand = 0;
      else if (non_if.tvalid) cand = 1;
      er = (cand == 0) && ofree;
      en = (cand == 1) && ofree;
      chk("roce_tready", roce_if.tready, er);
      chk("non_tready", non_if.tready, en);

      if (er && roce_if.tvalid) begin
        e.id = roce_if.tdata[31:0]; e.last = roce_if.tlast; e.cyc = 0;
        expq.push_back(e);
        mlast = 1'b1; mstate = e.last ? 0 : 1;
        if (e.last) exp_cnt[0]++;
      end else if (en && non_if.tvalid) begin
        e.id = non_if.tdata[31:0]; e.last = non_if.tlast; e.cyc = 0;
        expq.push_back(e);
        mlast = 1'b0; mstate = e.last ? 0 : 2;
        if (e.last) exp_cnt[1]++;
      end
    end
  end

  task automatic add_vec(input logic rv, input logic [31:0] rid, input logic nv, input logic [31:0] nid,
                         input logic e_rr, input logic e_nr, input logic e_mv, input logic [31:0] e_mid);
    vec_t v;
    v.rv = rv; v.rl = 1'b1; v.rid = rid; v.nv = nv; v.nl = 1'b1; v.nid = nid;
    v.e_rr = e_rr; v.e_nr = e_nr; v.e_mv = e_mv; v.e_mid = e_mid; v.e_ml = 1'b1;
    vt.push_back(v);
  endtask

  initial begin : global_guard
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin : main
    int base;
    int bud;
    int tot;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    set_src(0, 1'b1, 32'h999, 1'b1);
    set_src(1, 1'b1, 32'h998, 1'b1);
    m_if.tready = 1'b1;

    // reset: inputs valid but no ready while reset is held
    @(negedge clk);
    chk("rst_roce_tready", roce_if.tready, 1'b0);
    chk("rst_non_tready", non_if.tready, 1'b0);
    @(negedge clk);
    chk("rst_roce_tready2", roce_if.tready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_m_tvalid", m_if.tvalid, 1'b0);
    chk("rst_m_tlast", m_if.tlast, 1'b0);
    chk_w("rst_m_tdata", m_if.tdata, '0);
    chk("rst_m_tkeep", m_if.tkeep, 64'd0);
    chk("rst_m_tuser", m_if.tuser_size, 64'd0);
    chk("rst_roce_cnt", roce_cnt, 64'd0);
    chk("rst_non_cnt", non_cnt, 64'd0);
    mon_en = 1'b1;

    // tie table, single-beat packets, one beat per cycle
    if (PRIO) begin
      add_vec(1, 32'h101, 1, 32'h201, 1, 0, 1, 32'h101);
      add_vec(1, 32'h102, 1, 32'h201, 1, 0, 1, 32'h102);
      add_vec(1, 32'h103, 1, 32'h201, 1, 0, 1, 32'h103);
      add_vec(1, 32'h104, 1, 32'h201, 1, 0, 1, 32'h104);
      add_vec(0, 32'h0,   1, 32'h201, 0, 1, 1, 32'h201);
      add_vec(0, 32'h0,   1, 32'h202, 0, 1, 1, 32'h202);
      add_vec(0, 32'h0,   1, 32'h203, 0, 1, 1, 32'h203);
      add_vec(0, 32'h0,   1, 32'h204, 0, 1, 1, 32'h204);
    end else begin
      add_vec(1, 32'h101, 1, 32'h201, 1, 0, 1, 32'h101);
      add_vec(1, 32'h102, 1, 32'h201, 0, 1, 1, 32'h201);
      add_vec(1, 32'h102, 1, 32'h202, 1, 0, 1, 32'h102);
      add_vec(1, 32'h103, 1, 32'h202, 0, 1, 1, 32'h202);
      add_vec(1, 32'h103, 1, 32'h203, 1, 0, 1, 32'h103);
      add_vec(1, 32'h104, 1, 32'h203, 0, 1, 1, 32'h203);
      add_vec(1, 32'h104, 1, 32'h204, 1, 0, 1, 32'h104);
      add_vec(0, 32'h0,   1, 32'h204, 0, 1, 1, 32'h204);
    end
    add_vec(0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0);
    for (int i = 0; i < vt.size(); i++) begin
      set_src(0, vt[i].rv, vt[i].rid, vt[i].rl);
      set_src(1, vt[i].nv, vt[i].nid, vt[i].nl);
      @(negedge clk);
      chk("tbl_roce_tready", roce_if.tready, vt[i].e_rr);
      chk("tbl_non_tready", non_if.tready, vt[i].e_nr);
      @(posedge clk); #1;
      chk("tbl_m_tvalid", m_if.tvalid, vt[i].e_mv);
      if (vt[i].e_mv) begin
        chk("tbl_m_id", m_if.tdata[31:0], vt[i].e_mid);
        chk("tbl_m_tlast", m_if.tlast, vt[i].e_ml);
      end
    end
    chk("tbl_roce_cnt", roce_cnt, 64'd4);
    chk("tbl_non_cnt", non_cnt, 64'd4);

    // lock: roce 8-beat packet with a 2-cycle tvalid gap at beat 4
    base = lg.size();
    add_pkt(0, 8, 0, 4, 2);
    add_pkt(1, 2, 0, -1, 0);
    fork drive(0); drive(1); join
    repeat (3) @(posedge clk); #1;
    chk("lock_beats", lg.size() - base, 64'd10);
    if (lg.size() - base == 10) begin
      for (int k = 0; k < 8; k++) chk("lock_src_roce", lg[base + k].id[31:28], 64'd1);
      for (int k = 8; k < 10; k++) chk("lock_src_non", lg[base + k].id[31:28], 64'd2);
      chk("lock_bubbles", lg[base + 7].cyc - lg[base].cyc - 7, 64'd2);
      chk("lock_non_follows", lg[base + 8].cyc - lg[base + 7].cyc, 64'd1);
    end

    // backpressure: 5 stalled cycles after two output beats
    base = lg.size();
    add_pkt(0, 6, 0, -1, 0);
    add_pkt(1, 3, 0, -1, 0);
    fork
      drive(0);
      drive(1);
      begin
        bud = 0;
        while (lg.size() < base + 2 && bud < 200) begin @(posedge clk); #1; bud++; end
        if (lg.size() < base + 2) fail_now("bp_first_beats_timeout");
        m_if.tready = 1'b0;
        repeat (5) @(posedge clk); #1;
        m_if.tready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;
    chk("bp_beats", lg.size() - base, 64'd9);
    if (lg.size() - base == 9) begin
      for (int k = 0; k < 6; k++) chk("bp_src_roce", lg[base + k].id[31:28], 64'd1);
      chk("bp_span", lg[base + 8].cyc - lg[base].cyc, 64'd13);
    end

    // both sources continuously valid with 2-beat packets
    base = lg.size();
    for (int p = 0; p < 3; p++) begin add_pkt(0, 2, 0, -1, 0); add_pkt(1, 2, 0, -1, 0); end
    fork drive(0); drive(1); join
    repeat (3) @(posedge clk); #1;
    chk("arb_beats", lg.size() - base, 64'd12);
    if (lg.size() - base == 12) begin
      for (int p = 0; p < 6; p++)
        chk("arb_pkt_src", lg[base + 2 * p].id[31:28], PRIO ? ((p < 3) ? 64'd1 : 64'd2) : ((p % 2 == 0) ? 64'd1 : 64'd2));
      chk("arb_back_to_back", lg[base + 11].cyc - lg[base].cyc, 64'd11);
    end

    // counter wrap
    cnt_chk = 1'b0;
    @(negedge clk);
    force dut.roce_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.roce_cnt_q;
    @(posedge clk); #1;
    chk("wrap_preload_hold", roce_cnt, 64'hFFFF_FFFF);
    tot = exp_cnt[1];
    add_pkt(0, 1, 0, -1, 0);
    drive(0);
    repeat (2) @(posedge clk); #1;
    chk("wrap_roce_cnt", roce_cnt, 64'd0);
    chk("wrap_non_unchanged", non_cnt, 32'(tot));
    exp_cnt[0] = 0;
    @(posedge clk); #1;
    cnt_chk = 1'b1;

    // random traffic with random downstream backpressure
    base = lg.size();
    tot = 0;
    for (int p = 0; p < 20; p++) begin
      int l0 = $urandom_range(1, 4);
      int l1 = $urandom_range(1, 4);
      add_pkt(0, l0, $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2));
      add_pkt(1, l1, $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2));
      tot += l0 + l1;
    end
    rnd_done = 1'b0;
    fork
      begin fork drive(0); drive(1); join rnd_done = 1'b1; end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          m_if.tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_if.tready = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("rnd_beats", lg.size() - base, 32'(tot));
    chk("final_expq_empty", expq.size(), 64'd0);
    chk("final_m_tvalid", m_if.tvalid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/packet_tx_arbiter.md
# packet_tx_arbiter

- Transmit-side counterpart of the receive packet filter: merges RoCEv2 packets from the RDMA engine and non-RoCEv2 packets from the QDMA subsystem into one AXI-Stream toward the network MAC.
- Arbitrates on whole packets and keeps each packet intact from first beat to tlast.
- Provides a registered output stage and per-source packet counters.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 512, tdata width
- AXIS_KEEP_WIDTH, 64, tkeep width
- AXIS_USER_WIDTH, 16, tuser_size width (packet size sideband, passed through)

Ports:
- axis_aclk  in  1  single clock for the whole block
- axis_rst  in  1  reset; synchronous, active-high
- s_axis_roce_tvalid/tdata/tkeep/tuser_size/tlast  in  1/DATA/KEEP/USER/1  RoCEv2 packet input
- s_axis_roce_tready  out  1  ready for the RoCEv2 input
- s_axis_non_roce_tvalid/tdata/tkeep/tuser_size/tlast  in  1/DATA/KEEP/USER/1  non-RoCEv2 packet input
- s_axis_non_roce_tready  out  1  ready for the non-RoCEv2 input
- m_axis_tvalid/tdata/tkeep/tuser_size/tlast  out  1/DATA/KEEP/USER/1  merged packet output
- m_axis_tready  in  1  downstream ready
- roce_pkt_cnt  out  32  RoCEv2 packets accepted (count of tlast beats)
- non_roce_pkt_cnt  out  32  non-RoCEv2 packets accepted (count of tlast beats)

## Operation
- **Output register:**
  - Single stage holds one beat. `out_free = !m_axis_tvalid || m_axis_tready`.
  - The register loads on any accepted input beat.
  - If the register is not loaded and `m_axis_tready=1`, m_axis_tvalid clears.
- **FSM states:** ARB_IDLE, ARB_ROCE, ARB_NONROCE. The `last_grant` register records the source most recently granted.
- **ARB_IDLE (combinational grant, no bubble):**
  - Candidate source: a source with tvalid. If both have tvalid, pick the source that is not `last_grant` (round-robin).
  - The candidate's tready = `out_free`; the other source's tready = 0.
  - Candidate beat accepted with tlast=0: go to that source's locked state and set `last_grant` to it.
  - Candidate beat accepted with tlast=1: stay in ARB_IDLE and update `last_grant`.
- **ARB_ROCE / ARB_NONROCE (locked):**
  - Only the locked source gets tready = `out_free`. The other source sees tready = 0.
  - An accepted beat with tlast=1 returns the FSM to ARB_IDLE.
  - If the locked source drops tvalid mid-packet, the FSM stays locked. The output shows a bubble and the other source is not served.
- **Pass-through:** tdata, tkeep, tuser_size and tlast pass through unchanged. No per-beat check of tkeep or tuser_size.
- **Counters:** each increments on an accepted tlast beat from its source. 32-bit, wraps from 0xFFFF_FFFF to 0.

## Timing
- **Reset values:**
  - FSM in ARB_IDLE; `last_grant` = non-RoCE, so RoCE wins the first tie.
  - m_axis_tvalid=0; m_axis_tdata/tkeep/tuser_size/tlast all zero.
  - Both counters 0; both s_*_tready=0 while axis_rst=1.
- **Latency:** a beat accepted at edge N is presented on m_axis from cycle N+1.
- **Throughput:** sustained 1 beat/cycle with m_axis_tready=1, including back-to-back packets from either source. There is no idle cycle between packets.
- **Backpressure:** while m_axis_tvalid=1 and m_axis_tready=0, all m_axis fields hold stable and both s_*_tready are 0.
- **Single-beat packets:** the FSM never leaves ARB_IDLE; round-robin alternates per packet.
- **Reset mid-packet:** the held beat and the packet in flight are dropped and the FSM returns to ARB_IDLE. Downstream sees a truncated packet; this is acceptable on a reset event.

## Configuration
- Macro: `PKT_TX_ARB_ROCE_PRIO_EN`.
- **Defined:** strict priority. In ARB_IDLE, RoCE is chosen whenever s_axis_roce_tvalid=1, regardless of `last_grant`. A packet already in progress is never preempted.
- **Not defined:** round-robin as described in Operation.

## Test plan
- **Reset check:** hold axis_rst 3 cycles, then release → m_axis_tvalid=0, both counters 0, FSM serves the first valid beat on the next cycle.
- **Tie, single-beat packets:** both sources present 4 single-beat packets with tready=1 → output order R,N,R,N at 1 beat/cycle; roce_pkt_cnt=4, non_roce_pkt_cnt=4.
- **Lock:** RoCE 8-beat packet with tvalid low for 2 cycles at beat 4, non-RoCE valid throughout → no non-RoCE beat appears until the RoCE tlast has been output; 2 bubbles on m_axis.
- **Backpressure:** m_axis_tready low for 5 cycles mid-packet → m_axis fields constant, input tready=0, no beat lost or duplicated; sequence matches the reference model.
- **Macro:** `PKT_TX_ARB_ROCE_PRIO_EN` defined, both sources continuously valid with 2-beat packets → only RoCE packets are output, while non-RoCE is stalled. Without the macro → packets alternate.
- **Counter wrap:** force roce_pkt_cnt to 0xFFFF_FFFF, send one RoCE packet → roce_pkt_cnt=0.
